// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : rv32 instruction-fetch stage. It owns the PC, issues reads to
//               a 1-cycle synchronous ROM and buffers {pc, instr} pairs in a
//               credit-controlled queue toward IF/ID. A redirect flushes the
//               queue and any in-flight fetch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 4
) (
    input  logic                       clk_i_FU,
    input  logic                       reset_i_FU,
    output logic [ADDR_W-1:0]          pc_addr_o_FU,
    output logic                       chip_enable_o_FU,
    input  logic [INSTR_W-1:0]         instr_i_FU,
    input  logic                       redirect_i_FU,
    input  logic [ADDR_W-1:0]          redirect_pc_i_FU,
    output logic [INSTR_W-1:0]         instr_o_FU,
    output logic [ADDR_W-1:0]          pc_o_FU,
    output logic                       valid_o_FU,
    input  logic                       ready_i_FU,
    output logic [$clog2(DEPTH):0]     count_o_FU
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_rpc;
    logic               r_inflight;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;

    logic [INSTR_W-1:0] r_mem_instr [DEPTH];
    logic [ADDR_W-1:0]  r_mem_pc    [DEPTH];

    logic [c_CNT_W-1:0] w_occupancy;
    logic               w_issue;
    logic               w_valid;
    logic               w_push;
    logic               w_pop;

    // Occupancy counts the in-flight read so a returning response always has a slot.
    assign w_occupancy = r_count + c_CNT_W'(r_inflight);
    assign w_issue     = !reset_i_FU && !redirect_i_FU && (w_occupancy < c_CNT_W'(DEPTH));
    assign w_valid     = (r_count != '0);
    assign w_push      = r_inflight && !redirect_i_FU;
    assign w_pop       = w_valid && ready_i_FU && !redirect_i_FU;

    assign pc_addr_o_FU     = r_pc;
    assign chip_enable_o_FU = w_issue;
    assign valid_o_FU       = w_valid;
    assign count_o_FU       = r_count;
    assign instr_o_FU       = w_valid ? r_mem_instr[r_rptr] : '0;
    assign pc_o_FU          = w_valid ? r_mem_pc[r_rptr]    : '0;

    always_ff @(posedge clk_i_FU or posedge reset_i_FU) begin
        if (reset_i_FU) begin
            r_pc       <= RESET_PC;
            r_rpc      <= '0;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else if (redirect_i_FU) begin
            r_pc       <= {redirect_pc_i_FU[ADDR_W-1:2], 2'b00};
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc  <= r_pc + ADDR_W'(4);
                r_rpc <= r_pc;
            end
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    // Queue storage is intentionally left uninitialised; outputs are gated by valid.
    always_ff @(posedge clk_i_FU) begin
        if (!reset_i_FU && w_push) begin
            r_mem_instr[r_wptr] <= instr_i_FU;
            r_mem_pc[r_wptr]    <= r_rpc;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit with a ROM model
//               and a scoreboard of expected fetch PCs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    localparam logic [31:0] c_XOR = 32'hA5A5_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst         = 1'b1;
    logic        redirect    = 1'b0;
    logic        ready       = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] pc_addr, instr_in, instr_o, pc_o;
    logic        ce, valid;
    logic [2:0]  count;

    logic        rst8      = 1'b1;
    logic        ready8    = 1'b0;
    logic        redirect8 = 1'b0;
    logic [7:0]  rpc8      = 8'h0;
    logic [7:0]  pc_addr8, pc_o8;
    logic        ce8, valid8;
    logic [31:0] instr_in8, instr_o8;
    logic [2:0]  count8;

    logic [31:0] q  [$];
    logic [7:0]  q8 [$];
    int n_vec = 0;
    int n_err = 0;

    fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0), .DEPTH(4)) dut (
        .clk_i_FU(clk), .reset_i_FU(rst),
        .pc_addr_o_FU(pc_addr), .chip_enable_o_FU(ce), .instr_i_FU(instr_in),
        .redirect_i_FU(redirect), .redirect_pc_i_FU(redirect_pc),
        .instr_o_FU(instr_o), .pc_o_FU(pc_o), .valid_o_FU(valid),
        .ready_i_FU(ready), .count_o_FU(count)
    );

    fetch_unit #(.ADDR_W(8), .INSTR_W(32), .RESET_PC(8'hF8), .DEPTH(4)) dut8 (
        .clk_i_FU(clk), .reset_i_FU(rst8),
        .pc_addr_o_FU(pc_addr8), .chip_enable_o_FU(ce8), .instr_i_FU(instr_in8),
        .redirect_i_FU(redirect8), .redirect_pc_i_FU(rpc8),
        .instr_o_FU(instr_o8), .pc_o_FU(pc_o8), .valid_o_FU(valid8),
        .ready_i_FU(ready8), .count_o_FU(count8)
    );

    // Synchronous ROM: data for the strobed address appears one cycle later.
    always @(posedge clk) begin
        if (ce)  instr_in  <= pc_addr ^ c_XOR;
        if (ce8) instr_in8 <= {24'h0, pc_addr8} ^ c_XOR;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle; any handshake seen just before the edge is scored.
    task automatic step();
        logic [31:0] e;
        logic [7:0]  e8;
        #1;
        if (valid && ready && !redirect) begin
            n_vec++;
            assert (q.size() != 0) else begin
                n_err++;
                $error("FAIL pop_unexpected: observed pc %h, expected no output", pc_o);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("pop_pc", 64'(pc_o), 64'(e));
                chk("pop_instr", 64'(instr_o), 64'(e ^ c_XOR));
            end
        end
        if (valid8 && ready8) begin
            n_vec++;
            assert (q8.size() != 0) else begin
                n_err++;
                $error("FAIL pop8_unexpected: observed pc %h, expected no output", pc_o8);
            end
            if (q8.size() != 0) begin
                e8 = q8.pop_front();
                chk("pop8_pc", 64'(pc_o8), 64'(e8));
                chk("pop8_instr", 64'(instr_o8), 64'({24'h0, e8} ^ c_XOR));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        chk("sb_drained", 64'(q.size()), 64'd0);
        rst      = 1'b1;
        ready    = 1'b0;
        redirect = 1'b0;
        step();
        step();
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_ce", 64'(ce), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_instr", 64'(instr_o), 64'd0);
        chk("rst_pc", 64'(pc_o), 64'd0);
        rst = 1'b0;
    endtask

    initial begin
        // Reset and streaming with ready held high
        reset_dut();
        ready = 1'b1;
        #1;
        chk("s_ce1", 64'(ce), 64'd1);
        chk("s_addr1", 64'(pc_addr), 64'h0);
        chk("s_valid1", 64'(valid), 64'd0);
        q.push_back(32'h0); q.push_back(32'h4); q.push_back(32'h8); q.push_back(32'hC);
        step();
        #1;
        chk("s_addr2", 64'(pc_addr), 64'h4);
        chk("s_valid2", 64'(valid), 64'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("s_valid_run", 64'(valid), 64'd1);
            chk("s_ce_run", 64'(ce), 64'd1);
            step();
        end
        ready = 1'b0;

        // Backpressure fills the queue and stalls issue
        reset_dut();
        repeat (6) step();
        #1;
        chk("bp_count", 64'(count), 64'd4);
        chk("bp_ce", 64'(ce), 64'd0);
        chk("bp_addr", 64'(pc_addr), 64'h10);
        q.push_back(32'h0); q.push_back(32'h4); q.push_back(32'h8);
        q.push_back(32'hC); q.push_back(32'h10);
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid_run", 64'(valid), 64'd1);
            step();
        end
        ready = 1'b0;

        // Redirect with three queued entries and one fetch in flight
        reset_dut();
        ready = 1'b1;
        q.push_back(32'h0); q.push_back(32'h4);
        repeat (4) step();
        ready = 1'b0;
        step();
        step();
        #1;
        chk("rd_count_pre", 64'(count), 64'd3);
        chk("rd_addr_pre", 64'(pc_addr), 64'h18);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        #1;
        chk("rd_ce_during", 64'(ce), 64'd0);
        step();
        redirect = 1'b0;
        ready    = 1'b1;
        #1;
        chk("rd_valid_after", 64'(valid), 64'd0);
        chk("rd_count_after", 64'(count), 64'd0);
        chk("rd_ce_after", 64'(ce), 64'd1);
        chk("rd_addr_after", 64'(pc_addr), 64'h100);
        q.push_back(32'h100); q.push_back(32'h104);
        step();
        #1;
        chk("rd_stale_dropped", 64'(valid), 64'd0);
        step();
        step();
        step();
        ready = 1'b0;

        // Misaligned redirect while the head is being offered
        reset_dut();
        ready = 1'b1;
        q.push_back(32'h0);
        repeat (3) step();
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        #1;
        chk("mr_ce_during", 64'(ce), 64'd0);
        chk("mr_head_valid", 64'(valid), 64'd1);
        chk("mr_head_pc", 64'(pc_o), 64'h4);
        step();
        redirect = 1'b0;
        #1;
        chk("mr_valid_after", 64'(valid), 64'd0);
        chk("mr_ce_after", 64'(ce), 64'd1);
        chk("mr_addr_after", 64'(pc_addr), 64'h200);
        q.push_back(32'h200);
        repeat (3) step();
        ready = 1'b0;

        // Asynchronous reset between edges
        reset_dut();
        repeat (4) step();
        #1;
        chk("ar_count_pre", 64'(count), 64'd3);
        rst = 1'b1;
        #1;
        chk("ar_valid", 64'(valid), 64'd0);
        chk("ar_ce", 64'(ce), 64'd0);
        chk("ar_count", 64'(count), 64'd0);
        step();
        rst   = 1'b0;
        ready = 1'b1;
        q.push_back(32'h0);
        #1;
        chk("ar_restart_ce", 64'(ce), 64'd1);
        chk("ar_restart_addr", 64'(pc_addr), 64'h0);
        repeat (3) step();
        ready = 1'b0;
        chk("sb_drained_main", 64'(q.size()), 64'd0);

        // 8-bit PC wraps from FC to 00
        chk("w_rst_count", 64'(count8), 64'd0);
        rst8   = 1'b0;
        ready8 = 1'b1;
        q8.push_back(8'hF8); q8.push_back(8'hFC); q8.push_back(8'h00); q8.push_back(8'h04);
        #1;
        chk("w_addr0", 64'(pc_addr8), 64'hF8);
        step();
        #1;
        chk("w_addr1", 64'(pc_addr8), 64'hFC);
        step();
        #1;
        chk("w_addr2", 64'(pc_addr8), 64'h00);
        step();
        #1;
        chk("w_addr3", 64'(pc_addr8), 64'h04);
        step();
        step();
        step();
        ready8 = 1'b0;
        chk("sb_drained_wrap", 64'(q8.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch stage for the rv32 core. It replaces the free-running PC-to-ROM path with several additions:
- an owned PC register;
- issue to a synchronous instruction ROM with 1-cycle read latency;
- a buffered {pc, instr} queue toward IF/ID with a valid/ready handshake;
- a branch/jump redirect that flushes buffered and in-flight fetches.

It sits between the ROM and the IF/ID pipeline register.

Parameters:
ADDR_W, 32, PC / ROM address width in bits.
INSTR_W, 32, instruction width in bits.
RESET_PC, 32'h0000_0000, PC value after reset; bits [1:0] must be 0.
DEPTH, 4, fetch-queue entries; power of two, ≥2. Full throughput needs ≥4.

Ports:
clk_i_FU  input  1  core clock; all state is rising-edge.
reset_i_FU  input  1  asynchronous, active-high reset.
pc_addr_o_FU  output  ADDR_W  ROM read address (= pc_q).
chip_enable_o_FU  output  1  ROM read strobe; 1 = fetch issued this cycle.
instr_i_FU  input  INSTR_W  ROM read data; valid the cycle after chip_enable_o_FU=1.
redirect_i_FU  input  1  branch/jump taken; flush and refetch.
redirect_pc_i_FU  input  ADDR_W  redirect target address.
instr_o_FU  output  INSTR_W  instruction at queue head.
pc_o_FU  output  ADDR_W  PC of instruction at queue head.
valid_o_FU  output  1  queue head valid.
ready_i_FU  input  1  IF/ID accepts the head this cycle.
count_o_FU  output  clog2(DEPTH)+1  queue occupancy.

Behaviour:
- Reset (async, any time, including mid-fetch):
  - pc_q=RESET_PC, inflight_q=0, count=0, read/write pointers=0.
  - Outputs: chip_enable_o_FU=0, valid_o_FU=0, count_o_FU=0, instr_o_FU=0, pc_o_FU=0.
  - First issue occurs in the first clock cycle after reset deasserts.
- Issue (combinational): issue = !redirect_i_FU && (count + inflight_q < DEPTH).
  - chip_enable_o_FU=issue; pc_addr_o_FU=pc_q.
  - On issue at the edge: pc_q <= pc_q+4 (mod 2^ADDR_W, wraps silently); inflight_q <= 1, and rpc_q <= pc_q.
  - No issue: inflight_q <= 0.
- Response: when inflight_q=1, instr_i_FU and rpc_q are pushed at the tail at the edge. The credit rule guarantees no push into a full queue.
- Pop: valid_o_FU && ready_i_FU removes the head at the edge.
  - Push and pop in the same cycle: count unchanged.
  - Pop with count=0 is impossible because valid_o_FU=0.
- Outputs are registered from queue storage; valid_o_FU=(count!=0). There is no bypass.
- Latency: issue at cycle N → ROM data at N+1 → valid_o_FU at N+2.
- Throughput: 1 instr/cycle while ready_i_FU=1.
- Backpressure: when ready_i_FU=0, the queue fills, then chip_enable_o_FU drops. pc_q holds and no fetch is lost.
- Redirect (priority over issue, push and pop):
  - In the same cycle: chip_enable_o_FU=0; no push or pop happens, so the head is not consumed even if ready_i_FU=1.
  - At the edge: count<=0, pointers<=0, and inflight_q<=0. The response arriving next cycle is dropped.
  - pc_q <= {redirect_pc_i_FU[ADDR_W-1:2],2'b00}; low bits are ignored.
  - Next cycle: valid_o_FU=0 and the issue from the target occurs. The first target instruction appears 2 cycles after that.
- Back-to-back redirects: the last one wins; each one flushes.
- Pointer wrap: pointers are clog2(DEPTH) bits and wrap naturally.
- Queue storage contents are not reset-cleared beyond the output values given above.

Test Plan:
- Reset/stream. ROM model returns instr = addr ^ 32'hA5A5_0000; RESET_PC=0; ready=1.
  Release reset → chip_enable every cycle, addresses 0,4,8…
  First valid_o 2 cycles after the first issue, with pc_o=0, instr_o=A5A5_0000. Then pc_o=4,8,C on consecutive cycles.
- Backpressure: ready=0 from the start.
  → count_o reaches 4, chip_enable_o drops, pc_addr_o holds 0x10.
  Raise ready → pc_o 0,4,8,C,10 delivered with no gap, drop or duplicate.
- Redirect: redirect at pc_q=0x18 with target 0x100, while the queue holds 3 entries and one fetch is in flight.
  → next cycle valid_o=0 and count_o=0; issue from 0x100. The next valid pc_o is 0x100 and the stale 0x14 never appears.
- Redirect with misaligned target 0x203 while ready=1 → the head is not popped; fetch resumes at 0x200.
- Async reset mid-stream: assert reset between edges with count_o=3.
  → valid_o, chip_enable_o and count_o go 0 immediately, without waiting for an edge. Restart at RESET_PC.
- Wrap: ADDR_W=8, RESET_PC=8'hF8 → fetched addresses F8, FC, 00, 04; pc_o follows the same order.
